spi_ram_bridge: RTL and testbench

SPI_RAM_BRIDGE -- requirements
Module: spi_ram_bridge

---
 rtl/spi_ram_bridge.sv | 176 +++++++++++++++++
 tb/tb_spi_ram_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_bridge.sv
// SPI-slave command bridge to an internal single-port RAM (write/read pointers, address and data frames).
// Define SPI_RAM_BURST_EN to stream words continuously while ss_n stays low; otherwise one word per data frame.
module spi_ram_bridge #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ss_n,
  input  logic mosi,
  output logic miso
);

  localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(SH_W) + 1;

  typedef enum logic [2:0] {
    IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_TURN, RD_DATA
  } state_t;

  state_t            state_reg, state_next;
  logic [SH_W-2:0]   sh_in_reg, sh_in_next;
  logic [SH_W-1:0]   sh_cat;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] sh_out_reg, sh_out_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic              miso_reg, miso_next;
  logic              done_reg, done_next;
  logic              cmd_bit_reg, cmd_bit_next;
  logic              armed_reg;
  logic              last_addr_bit, last_data_bit;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_word_reg;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  assign miso = miso_reg;

  always_comb begin
    state_next    = state_reg;
    sh_in_next    = sh_in_reg;
    cnt_next      = cnt_reg;
    sh_out_next   = sh_out_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    done_next     = done_reg;
    cmd_bit_next  = cmd_bit_reg;
    miso_next     = 1'b0;
    sh_cat        = {sh_in_reg, mosi};
    last_addr_bit = (cnt_reg == CNT_W'(ADDR_W - 1));
    last_data_bit = (cnt_reg == CNT_W'(DATA_W - 1));
    ram_we        = 1'b0;
    ram_addr      = rd_ptr_reg;
    ram_wdata     = sh_cat[DATA_W-1:0];

    if (ss_n) begin
      // Frame end: drop any partial word, the bit on this edge is not sampled.
      state_next = IDLE;
      sh_in_next = '0;
      cnt_next   = '0;
      done_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (armed_reg) begin
            cmd_bit_next = mosi;
            state_next   = CMD;
          end
        end
        CMD: begin
          cnt_next   = '0;
          sh_in_next = '0;
          done_next  = 1'b0;
          case ({cmd_bit_reg, mosi})
            2'b00:   state_next = WR_ADDR;
            2'b01:   state_next = WR_DATA;
            2'b10:   state_next = RD_ADDR;
            default: state_next = RD_TURN;
          endcase
        end
        WR_ADDR, RD_ADDR: begin
          if (!done_reg) begin
            if (last_addr_bit) begin
              if (state_reg == WR_ADDR) wr_ptr_next = sh_cat[ADDR_W-1:0];
              else                      rd_ptr_next = sh_cat[ADDR_W-1:0];
              done_next = 1'b1;
              cnt_next  = '0;
            end else begin
              sh_in_next = sh_cat[SH_W-2:0];
              cnt_next   = cnt_reg + CNT_W'(1);
            end
          end
        end
        WR_DATA: begin
          if (!done_reg) begin
            if (last_data_bit) begin
              ram_we      = 1'b1;
              ram_addr    = wr_ptr_reg;
              wr_ptr_next = wr_ptr_reg + 1'b1;
              cnt_next    = '0;
              sh_in_next  = '0;
`ifndef SPI_RAM_BURST_EN
              done_next   = 1'b1;
`endif
            end else begin
              sh_in_next = sh_cat[SH_W-2:0];
              cnt_next   = cnt_reg + CNT_W'(1);
            end
          end
        end
        RD_TURN: begin
          // rd_word_reg was read from rd_ptr on the edge that entered this state.
          {miso_next, sh_out_next} = {rd_word_reg, 1'b0};
          rd_ptr_next = rd_ptr_reg + 1'b1;
          cnt_next    = '0;
          state_next  = RD_DATA;
        end
        RD_DATA: begin
          if (!done_reg) begin
            if (last_data_bit) begin
              cnt_next = '0;
`ifdef SPI_RAM_BURST_EN
              // Prefetched word at the already-incremented rd_ptr keeps the stream gapless.
              {miso_next, sh_out_next} = {rd_word_reg, 1'b0};
              rd_ptr_next = rd_ptr_reg + 1'b1;
`else
              done_next = 1'b1;
`endif
            end else begin
              miso_next   = sh_out_reg[DATA_W-1];
              sh_out_next = sh_out_reg << 1;
              cnt_next    = cnt_reg + CNT_W'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      sh_in_reg   <= '0;
      cnt_reg     <= '0;
      sh_out_reg  <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      miso_reg    <= 1'b0;
      done_reg    <= 1'b0;
      cmd_bit_reg <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sh_in_reg   <= sh_in_next;
      cnt_reg     <= cnt_next;
      sh_out_reg  <= sh_out_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      miso_reg    <= miso_next;
      done_reg    <= done_next;
      cmd_bit_reg <= cmd_bit_next;
      armed_reg   <= armed_reg | ss_n;
    end
  end

  // RAM contents survive reset; a write is suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (ram_we && rst_n) mem[ram_addr] <= ram_wdata;
    rd_word_reg <= mem[ram_addr];
  end

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Self-checking bench for spi_ram_bridge: randomized frames against an array-based RAM/pointer model.
module tb_spi_ram_bridge;

  localparam int AW = 8;
  localparam int DW = 8;
`ifdef SPI_RAM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ss_n = 1'b1;
  logic mosi = 1'b0;
  logic miso;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] model_mem [256];
  logic [7:0] m_wr;
  logic [7:0] m_rd;

  spi_ram_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ss_n (ss_n),
    .mosi (mosi),
    .miso (miso)
  );

  always #5 clk = ~clk;

  task automatic drive_bit(input logic b);
    @(negedge clk);
    ss_n = 1'b0;
    mosi = b;
  endtask

  task automatic end_frame();
    @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) drive_bit(v[i]);
  endtask

  task automatic set_ptr(input logic rd, input logic [7:0] a);
    drive_bit(rd);
    drive_bit(1'b0);
    send_byte(a);
    end_frame();
    if (rd) m_rd = a;
    else    m_wr = a;
  endtask

  // Word w of the frame is data[8*w +: 8]; only the first word lands unless bursting.
  task automatic write_words(input int n, input logic [31:0] data);
    drive_bit(1'b0);
    drive_bit(1'b1);
    for (int w = 0; w < n; w++) begin
      send_byte(data[8*w +: 8]);
      if (BURST || w == 0) begin
        model_mem[m_wr] = data[8*w +: 8];
        m_wr = m_wr + 8'd1;
      end
    end
    end_frame();
  endtask

  task automatic read_frame(input int n, output logic turn_bit, output logic [31:0] got);
    got = '0;
    drive_bit(1'b1);
    drive_bit(1'b1);
    @(negedge clk);
    mosi = 1'($urandom);
    turn_bit = miso;
    for (int i = 0; i < 8 * n; i++) begin
      @(negedge clk);
      got = {got[30:0], miso};
      mosi = 1'($urandom);
    end
    ss_n = 1'b1;
  endtask

  function automatic logic [31:0] model_read(input int n);
    logic [31:0] e;
    logic [7:0]  a;
    e = '0;
    for (int w = 0; w < n; w++) begin
      a = m_rd + 8'(w);
      e = {e[23:0], (BURST || w == 0) ? model_mem[a] : 8'h00};
    end
    return e;
  endfunction

  function automatic void model_read_done(input int n);
    m_rd = m_rd + (BURST ? 8'(n) : 8'd1);
  endfunction

  task automatic test_reset();
    logic        tb;
    logic [31:0] got, exp;
    rst_n = 1'b0;
    ss_n  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_wr = 8'h00;
    m_rd = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (miso !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_miso: got %b want 0", miso);
      end
    end
    write_words(1, 32'($urandom));
    exp = model_read(1);
    read_frame(1, tb, got);
    model_read_done(1);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_ptrs: read %h want %h", got, exp);
    end
    $display("reset: read addr 00 -> %h", got[7:0]);
  endtask

  task automatic test_fill();
    for (int a = 1; a < 256; a++) write_words(1, 32'($urandom));
  endtask

  task automatic test_basic();
    logic        tb;
    logic [31:0] got;
    set_ptr(1'b0, 8'h10);
    write_words(1, 32'h0000_00A5);
    set_ptr(1'b1, 8'h10);
    read_frame(1, tb, got);
    model_read_done(1);
    n_cmp++;
    if (tb !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_turn: miso %b want 0", tb);
    end
    n_cmp++;
    if (got !== 32'h0000_00A5) begin
      n_fail++;
      $display("FAIL basic_read: got %h want a5", got);
    end
    $display("basic: read addr 10 -> %h", got[7:0]);
  endtask

  task automatic test_burst_wrap();
    logic        tb;
    logic [31:0] got, exp;
    set_ptr(1'b0, 8'hFE);
    write_words(3, 32'h0033_2211);
    set_ptr(1'b1, 8'hFE);
    exp = model_read(3);
    read_frame(3, tb, got);
    model_read_done(3);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL burst_read: got %h want %h", got, exp);
    end
    if (BURST) begin
      n_cmp++;
      if (got[23:0] !== 24'h11_2233) begin
        n_fail++;
        $display("FAIL burst_wrap: got %h want 112233", got[23:0]);
      end
    end
    $display("burst: read FE x3 -> %h", got[23:0]);
    // Single-word frames across the pointer wrap.
    set_ptr(1'b0, 8'hFF);
    write_words(1, 32'h0000_0044);
    write_words(1, 32'h0000_0055);
    set_ptr(1'b1, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      exp = model_read(1);
      read_frame(1, tb, got);
      model_read_done(1);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL wrap_read%0d: got %h want %h", i, got, exp);
      end
      $display("wrap: read -> %h", got[7:0]);
    end
  endtask

  task automatic test_abort();
    logic        tb;
    logic [31:0] got, exp;
    set_ptr(1'b0, 8'h20);
    write_words(1, 32'h0000_005A);
    set_ptr(1'b0, 8'h20);
    drive_bit(1'b0);
    drive_bit(1'b1);
    for (int i = 0; i < 5; i++) drive_bit(1'($urandom));
    end_frame();
    set_ptr(1'b1, 8'h20);
    read_frame(1, tb, got);
    model_read_done(1);
    n_cmp++;
    if (got !== 32'h0000_005A) begin
      n_fail++;
      $display("FAIL abort_data: got %h want 5a", got);
    end
    // A full word now must still land at 0x20.
    write_words(1, 32'h0000_00C3);
    // Aborted read-address frame leaves rd_ptr at 0x21.
    drive_bit(1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'($urandom));
    end_frame();
    exp = model_read(1);
    read_frame(1, tb, got);
    model_read_done(1);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL abort_addr: got %h want %h", got, exp);
    end
    set_ptr(1'b1, 8'h20);
    read_frame(1, tb, got);
    model_read_done(1);
    n_cmp++;
    if (got !== 32'h0000_00C3) begin
      n_fail++;
      $display("FAIL abort_wrptr: got %h want c3", got);
    end
    $display("abort: read addr 20 -> %h", got[7:0]);
  endtask

  task automatic test_single_word();
    logic        tb;
    logic [31:0] got, exp;
    set_ptr(1'b0, 8'h30);
    write_words(2, 32'h0000_7766);
    set_ptr(1'b1, 8'h30);
    for (int i = 0; i < 2; i++) begin
      exp = model_read(1);
      read_frame(1, tb, got);
      model_read_done(1);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL single_word%0d: got %h want %h", i, got, exp);
      end
      $display("single: read -> %h", got[7:0]);
    end
  endtask

  task automatic test_reset_mid_read();
    logic        tb;
    logic [31:0] got, exp;
    set_ptr(1'b0, 8'h40);
    write_words(1, 32'h0000_00FF);
    set_ptr(1'b1, 8'h40);
    drive_bit(1'b1);
    drive_bit(1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (miso !== 1'b0) begin
      n_fail++;
      $display("FAIL midread_miso: got %b want 0", miso);
    end
    rst_n = 1'b1;
    m_wr = 8'h00;
    m_rd = 8'h00;
    // ss_n never went high since reset: this pseudo-frame must be ignored.
    drive_bit(1'b0);
    drive_bit(1'b1);
    send_byte(~model_mem[0]);
    end_frame();
    exp = model_read(1);
    read_frame(1, tb, got);
    model_read_done(1);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL midread_rdptr: got %h want %h", got, exp);
    end
    set_ptr(1'b1, 8'h40);
    read_frame(1, tb, got);
    model_read_done(1);
    n_cmp++;
    if (got !== 32'h0000_00FF) begin
      n_fail++;
      $display("FAIL midread_ram: got %h want ff", got);
    end
    $display("midread reset: read addr 40 -> %h", got[7:0]);
  endtask

  task automatic test_back_to_back();
    logic        tb;
    logic [31:0] got, exp;
    int          n;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(3))
        0: set_ptr(1'b0, 8'($urandom));
        1: set_ptr(1'b1, 8'($urandom));
        2: write_words($urandom_range(1, 3), 32'($urandom));
        default: begin
          n = $urandom_range(1, 3);
          exp = model_read(n);
          read_frame(n, tb, got);
          model_read_done(n);
          n_cmp++;
          if (tb !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_turn%0d: miso %b want 0", it, tb);
          end
          n_cmp++;
          if (got !== exp) begin
            n_fail++;
            $display("FAIL b2b_read%0d: got %h want %h", it, got, exp);
          end
          $display("b2b %0d: read %0d words -> %h", it, n, got);
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_burst_wrap();
    test_abort();
    test_single_word();
    test_reset_mid_read();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
